layer_priority_mixer: RTL and testbench
=======================================

# layer_priority_mixer

Parametrised successor to the two-plus-one-input priority mixer. It resolves the final palette index from `NUM_LAYERS` tile/sprite layers and a background colour, using per-layer 4-entry priority tables. CPU register writes can be applied immediately or deferred to vblank. An optional nibble-blend is applied between the top two layers. It sits between the layer generators and the palette RAM lookup, advancing only on `ce_pixel`.

## Interface
- `NUM_LAYERS`, 4: number of layer inputs; legal range 2..8.
- `COLOR_W`, 12: palette index width per layer; minimum 8.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce_pixel` in 1: pixel clock enable; the pipeline advances only when high.
- `cs` in 1: register select.
- `cpu_rw` in 1: 1 = read, 0 = write.
- `cpu_addr` in 5: register byte address.
- `cpu_ds_n` in 2: data strobes; only `[0]` is used.
- `cpu_din` in 8: write data.
- `cpu_dout` out 8: registered read data.
- `vblank` in 1: vertical blank from the video timing block.
- `layer_in` in `NUM_LAYERS*(COLOR_W+2)`: layer k occupies slice `[k*(COLOR_W+2) +: COLOR_W+2]`.
  - Top 2 bits of the slice: table select `sel_k`.
  - Low `COLOR_W` bits: colour.
- `color_out` out `COLOR_W`: resolved palette index.
- `out_layer` out 4: index of the winning layer; `NUM_LAYERS` when background wins.

## Operation
- Register map, each register 8 bits:
  - 0x00 CTRL: bit0 `latch_mode`, bit1 `blend_en`; other bits read back as written.
  - 0x02+2k / 0x03+2k, for k < `NUM_LAYERS`: priority table of layer k as 16 bits `{reg[3+2k], reg[2+2k]}`. Entry s is bits `[4s+3:4s]`.
  - 0x12 / 0x13: background colour. Low byte is in 0x12; 0x13 holds the upper `COLOR_W-8` bits, and unused bits are ignored.
  - Any other address, or a table register of a layer ≥ `NUM_LAYERS`: writes are ignored and reads return 0x00.
- Shadow and active register banks:
  - CPU writes (`cs & ~cpu_rw & ~cpu_ds_n[0]`) always update the shadow bank.
  - If `latch_mode`=0, the active bank is written in the same cycle.
  - If `latch_mode`=1, the whole shadow bank is copied to the active bank on the cycle after a `vblank` rising edge. The edge is detected from a registered copy of `vblank`.
  - CTRL is always immediate and is not shadowed.
  - Mixing uses only the active bank. Reads return the shadow bank.
- Write in the same cycle as a vblank copy: the copy uses the pre-write shadow value. The new value stays in shadow until the next vblank, unless `latch_mode`=0.
- Reads: `cpu_dout` is loaded on the cycle `cs & cpu_rw` is high and is otherwise held.
- Transparency: a layer is transparent when `colour[3:0]`=0. A transparent layer's effective priority is 0.
- Visibility: the effective priority of a non-transparent layer is its table entry at `sel_k`. Priority 0 is never visible.
- Winner selection:
  - The winner is the highest effective priority.
  - On a tie, the lower layer index wins.
  - The runner-up is the highest among the remaining layers, using the same tie rule.
- Output selection:
  - No visible layer: output the background colour and `out_layer` = `NUM_LAYERS`.
  - Otherwise output the winner's colour.
- Blend: when `blend_en`=1, runner-up priority ≠ 0, and `prio_win == prio_run + 1`:
  - `color_out` = `{win[COLOR_W-1:4], run[3:0]}`.
  - `out_layer` = winner.
- All priority arithmetic is 4-bit unsigned. A winner priority of 0 cannot satisfy the blend condition, so there is no wrap case.

## Timing
- Three-stage pipeline. Every stage register is enabled by `ce_pixel`.
  - S1: table lookup, registering effective priorities and colours.
  - S2: winner/runner-up selection, registered.
  - S3: background/blend mux into `color_out` / `out_layer`.
- Latency: an input sampled at `ce_pixel` edge n appears on the outputs after `ce_pixel` edge n+2. Throughput is 1 pixel per `ce_pixel`.
- Outputs are held when `ce_pixel`=0.
- Register effect latency, `latch_mode`=0: a write at cycle t is used by S1 from cycle t+1.
- Register effect latency, `latch_mode`=1: a write is used from the `ce_pixel` after the vblank copy.
- Reset (asynchronous assert, any time including mid-pixel):
  - All registers, both banks, clear to 0.
  - All pipeline stages clear to 0.
  - `cpu_dout`=0x00, `color_out`=0, `out_layer`=0.
- First output after reset: the background colour (0) with `out_layer`=`NUM_LAYERS` once 3 `ce_pixel` have elapsed. Until then, outputs hold their reset values.

## Test plan
- Reset, then 4 layers all colour 0, background 0x123, `ce_pixel` held high → `color_out`=0x123 and `out_layer`=4 from the 3rd cycle onward.
- Layer tables 0x1111 / 0x2222 / 0x3333 / 0x4444; layers 0..3 colours 0x101/0x202/0x303/0x404, all sel 0 → `color_out`=0x404, `out_layer`=3. Set layer 3 colour to 0x400 → `color_out`=0x303, `out_layer`=2, three `ce_pixel` later.
- Equal priority 5 on layers 1 and 2 → layer 1 wins. With `ce_pixel` toggling every 4th cycle, latency is exactly 3 enables.
- `blend_en`=1, layer 0 priority 7 colour 0xAB5, layer 1 priority 6 colour 0xCD9 → `color_out`=0xAB9. Change layer 1 priority to 5 → `color_out`=0xAB5.
- `latch_mode`=1, then write layer 0 table 0x000F while `vblank`=0 → mixing is unchanged and readback is 0x0F. Raise `vblank` → the new table takes effect. Repeat with the write in the copy cycle → the write is deferred to the next vblank.
- Write/read 0x1F → reads 0x00. Assert `reset_n` low mid-stream → all outputs are 0 immediately.

Source files
------------

// File: rtl/layer_priority_mixer_if.sv
// rtl/layer_priority_mixer_if.sv - CPU register bus for the layer priority mixer
interface layer_priority_mixer_if;
  logic       cs;
  logic       cpu_rw;
  logic [4:0] cpu_addr;
  logic [1:0] cpu_ds_n;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  modport master (output cs, output cpu_rw, output cpu_addr, output cpu_ds_n,
                  output cpu_din, input cpu_dout);
  modport slave  (input cs, input cpu_rw, input cpu_addr, input cpu_ds_n,
                  input cpu_din, output cpu_dout);
endinterface

// File: rtl/layer_priority_mixer.sv
// rtl/layer_priority_mixer.sv - N-layer priority resolver with shadowed tables and nibble blend
module layer_priority_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                ce_pixel,
  layer_priority_mixer_if.slave               bus,
  input  logic                                vblank,
  input  logic [NUM_LAYERS*(COLOR_W+2)-1:0]   layer_in,
  output logic [COLOR_W-1:0]                  color_out,
  output logic [3:0]                          out_layer
);

  localparam int SLICE_W = COLOR_W + 2;
  localparam int HI_W = (COLOR_W > 16) ? 8 : COLOR_W - 8;
  localparam logic [7:0] BG_HI_MASK = 8'((16'd1 << HI_W) - 16'd1);

  logic [7:0]  ctrl;
  logic [15:0] sh_tab  [NUM_LAYERS];
  logic [15:0] act_tab [NUM_LAYERS];
  logic [7:0]  sh_bg_lo, sh_bg_hi, act_bg_lo, act_bg_hi;
  logic        vb_q;

  logic        wr_en, copy, tab_hit;
  logic [4:0]  addr;
  logic [3:0]  tab_idx;
  logic [7:0]  rd_data;

  assign addr    = bus.cpu_addr;
  assign wr_en   = bus.cs & ~bus.cpu_rw & ~bus.cpu_ds_n[0];
  assign copy    = ctrl[0] & vblank & ~vb_q;
  assign tab_hit = (addr >= 5'd2) && (addr < 5'(2 + 2 * NUM_LAYERS));
  assign tab_idx = 4'((addr - 5'd2) >> 1);

  always_comb begin
    rd_data = 8'h00;
    if (addr == 5'h00)      rd_data = ctrl;
    else if (tab_hit)       rd_data = addr[0] ? sh_tab[tab_idx][15:8] : sh_tab[tab_idx][7:0];
    else if (addr == 5'h12) rd_data = sh_bg_lo;
    else if (addr == 5'h13) rd_data = sh_bg_hi;
  end

  // The vblank copy reads the shadow before this cycle's write lands in it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl         <= 8'h00;
      vb_q         <= 1'b0;
      sh_bg_lo     <= 8'h00;
      sh_bg_hi     <= 8'h00;
      act_bg_lo    <= 8'h00;
      act_bg_hi    <= 8'h00;
      bus.cpu_dout <= 8'h00;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        sh_tab[k]  <= 16'h0000;
        act_tab[k] <= 16'h0000;
      end
    end else begin
      vb_q <= vblank;
      if (copy) begin
        act_bg_lo <= sh_bg_lo;
        act_bg_hi <= sh_bg_hi;
        for (int k = 0; k < NUM_LAYERS; k++) act_tab[k] <= sh_tab[k];
      end
      if (wr_en) begin
        if (addr == 5'h00) ctrl <= bus.cpu_din;
        if (tab_hit) begin
          if (addr[0]) sh_tab[tab_idx][15:8] <= bus.cpu_din;
          else         sh_tab[tab_idx][7:0]  <= bus.cpu_din;
          if (!ctrl[0]) begin
            if (addr[0]) act_tab[tab_idx][15:8] <= bus.cpu_din;
            else         act_tab[tab_idx][7:0]  <= bus.cpu_din;
          end
        end
        if (addr == 5'h12) begin
          sh_bg_lo <= bus.cpu_din;
          if (!ctrl[0]) act_bg_lo <= bus.cpu_din;
        end
        if (addr == 5'h13) begin
          sh_bg_hi <= bus.cpu_din & BG_HI_MASK;
          if (!ctrl[0]) act_bg_hi <= bus.cpu_din & BG_HI_MASK;
        end
      end
      if (bus.cs && bus.cpu_rw) bus.cpu_dout <= rd_data;
    end
  end

  logic [3:0]         prio_eff [NUM_LAYERS];
  logic [3:0]         s1_prio  [NUM_LAYERS];
  logic [COLOR_W-1:0] s1_col   [NUM_LAYERS];
  logic [COLOR_W-1:0] s1_bg, s2_bg, s2_wcol, s2_rcol;
  logic               s1_blend, s2_blend, v1, v2;
  logic [3:0]         w_idx, r_idx, w_prio, r_prio;
  logic [3:0]         s2_widx, s2_wprio, s2_rprio;

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      logic [SLICE_W-1:0] sl;
      logic [15:0]        tab;
      sl  = layer_in[k*SLICE_W +: SLICE_W];
      tab = act_tab[k];
      prio_eff[k] = (sl[3:0] == 4'h0) ? 4'h0 : tab[4*sl[SLICE_W-1:SLICE_W-2] +: 4];
    end
  end

  // Strict compare keeps the lowest index on ties, for both winner and runner-up.
  always_comb begin
    w_idx  = 4'd0;
    w_prio = 4'd0;
    for (int k = 0; k < NUM_LAYERS; k++)
      if (s1_prio[k] > w_prio) begin
        w_idx  = 4'(k);
        w_prio = s1_prio[k];
      end
    r_idx  = (w_idx == 4'd0) ? 4'd1 : 4'd0;
    r_prio = 4'd0;
    for (int k = 0; k < NUM_LAYERS; k++)
      if (4'(k) != w_idx && s1_prio[k] > r_prio) begin
        r_idx  = 4'(k);
        r_prio = s1_prio[k];
      end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0; v2 <= 1'b0;
      s1_bg <= '0; s1_blend <= 1'b0;
      s2_bg <= '0; s2_blend <= 1'b0; s2_wcol <= '0; s2_rcol <= '0;
      s2_widx <= 4'd0; s2_wprio <= 4'd0; s2_rprio <= 4'd0;
      color_out <= '0; out_layer <= 4'd0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        s1_prio[k] <= 4'd0;
        s1_col[k]  <= '0;
      end
    end else if (ce_pixel) begin
      v1 <= 1'b1;
      v2 <= v1;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        s1_prio[k] <= prio_eff[k];
        s1_col[k]  <= layer_in[k*SLICE_W +: COLOR_W];
      end
      s1_bg    <= COLOR_W'({act_bg_hi, act_bg_lo});
      s1_blend <= ctrl[1];
      s2_bg    <= s1_bg;
      s2_blend <= s1_blend;
      s2_widx  <= w_idx;
      s2_wprio <= w_prio;
      s2_rprio <= r_prio;
      s2_wcol  <= s1_col[w_idx];
      s2_rcol  <= s1_col[r_idx];
      // Outputs keep reset values until the pipeline holds real data.
      if (v2) begin
        if (s2_wprio == 4'd0) begin
          color_out <= s2_bg;
          out_layer <= 4'(NUM_LAYERS);
        end else if (s2_blend && s2_rprio != 4'd0 && s2_wprio == s2_rprio + 4'd1) begin
          color_out <= {s2_wcol[COLOR_W-1:4], s2_rcol[3:0]};
          out_layer <= s2_widx;
        end else begin
          color_out <= s2_wcol;
          out_layer <= s2_widx;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_priority_mixer.sv
// tb/tb_layer_priority_mixer.sv - directed self-checking bench for layer_priority_mixer
module tb_layer_priority_mixer;
  localparam int NL = 4;
  localparam int CW = 12;
  localparam int SW = CW + 2;

  logic           clk, reset_n, ce_pixel, vblank;
  logic [NL*SW-1:0] layer_in;
  logic [CW-1:0]  color_out;
  logic [3:0]     out_layer;
  logic [7:0]     rd;
  int             n_checks, n_fail;

  layer_priority_mixer_if bus ();

  layer_priority_mixer #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .bus(bus),
    .vblank(vblank), .layer_in(layer_in), .color_out(color_out), .out_layer(out_layer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_ds_n = 2'b10;
    bus.cpu_addr = a; bus.cpu_din = d;
    step(1);
    bus.cs = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_ds_n = 2'b11;
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = a;
    step(1);
    d = bus.cpu_dout;
    bus.cs = 1'b0;
  endtask

  task automatic set_layer(input int k, input logic [1:0] sel, input logic [CW-1:0] col);
    layer_in[k*SW +: SW] = {sel, col};
  endtask

  task automatic pulse_ce();
    ce_pixel = 1'b1;
    step(1);
    ce_pixel = 1'b0;
    step(3);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; ce_pixel = 1'b0; vblank = 1'b0; layer_in = '0;
    bus.cs = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_ds_n = 2'b11;
    bus.cpu_addr = 5'h00; bus.cpu_din = 8'h00;
    step(2);
    check("rst_color", color_out, 0);
    check("rst_layer", out_layer, 0);
    check("rst_dout", bus.cpu_dout, 0);
    reset_n = 1'b1;
    step(1);

    // background only; outputs stay at reset values for two enables
    cpu_write(5'h12, 8'h23);
    cpu_write(5'h13, 8'h01);
    ce_pixel = 1'b1;
    step(1);
    check("fill1_color", color_out, 0);
    step(1);
    check("fill2_color", color_out, 0);
    check("fill2_layer", out_layer, 0);
    step(1);
    check("bg_color", color_out, 12'h123);
    check("bg_layer", out_layer, 4);
    step(2);
    check("bg_hold", color_out, 12'h123);

    // straight priority ladder
    cpu_write(5'h02, 8'h11); cpu_write(5'h03, 8'h11);
    cpu_write(5'h04, 8'h22); cpu_write(5'h05, 8'h22);
    cpu_write(5'h06, 8'h33); cpu_write(5'h07, 8'h33);
    cpu_write(5'h08, 8'h44); cpu_write(5'h09, 8'h44);
    set_layer(0, 2'd0, 12'h101); set_layer(1, 2'd0, 12'h202);
    set_layer(2, 2'd0, 12'h303); set_layer(3, 2'd0, 12'h404);
    step(6);
    check("ladder_color", color_out, 12'h404);
    check("ladder_layer", out_layer, 3);
    set_layer(3, 2'd0, 12'h400);
    step(2);
    check("transp_early", color_out, 12'h404);
    step(1);
    check("transp_color", color_out, 12'h303);
    check("transp_layer", out_layer, 2);

    // tie on priority 5, then latency under sparse enables
    cpu_write(5'h04, 8'h55); cpu_write(5'h05, 8'h55);
    cpu_write(5'h06, 8'h55); cpu_write(5'h07, 8'h55);
    step(6);
    check("tie_color", color_out, 12'h202);
    check("tie_layer", out_layer, 1);
    ce_pixel = 1'b0;
    set_layer(1, 2'd0, 12'h200);
    step(4);
    check("ce_hold", color_out, 12'h202);
    pulse_ce();
    check("ce_pulse1", color_out, 12'h202);
    pulse_ce();
    check("ce_pulse2", color_out, 12'h202);
    pulse_ce();
    check("ce_pulse3_color", color_out, 12'h303);
    check("ce_pulse3_layer", out_layer, 2);

    // nibble blend
    ce_pixel = 1'b1;
    cpu_write(5'h00, 8'h02);
    cpu_write(5'h02, 8'h07); cpu_write(5'h03, 8'h00);
    cpu_write(5'h04, 8'h06); cpu_write(5'h05, 8'h00);
    set_layer(0, 2'd0, 12'hAB5); set_layer(1, 2'd0, 12'hCD9);
    set_layer(2, 2'd0, 12'h300); set_layer(3, 2'd0, 12'h400);
    step(6);
    check("blend_color", color_out, 12'hAB9);
    check("blend_layer", out_layer, 0);
    cpu_read(5'h00, rd);
    check("ctrl_read", rd, 8'h02);
    cpu_write(5'h04, 8'h05);
    step(6);
    check("noblend_color", color_out, 12'hAB5);
    check("noblend_layer", out_layer, 0);

    // deferred writes through the vblank copy
    cpu_write(5'h02, 8'h00);
    step(6);
    check("pre_latch_color", color_out, 12'hCD9);
    cpu_write(5'h00, 8'h01);
    cpu_write(5'h02, 8'h0F);
    step(6);
    check("latch_unchanged", color_out, 12'hCD9);
    check("latch_unch_layer", out_layer, 1);
    cpu_read(5'h02, rd);
    check("shadow_read", rd, 8'h0F);
    vblank = 1'b1;
    step(6);
    check("vb_color", color_out, 12'hAB5);
    check("vb_layer", out_layer, 0);
    vblank = 1'b0;
    step(2);
    vblank = 1'b1;
    cpu_write(5'h02, 8'h00);
    step(6);
    check("copy_cycle_keep", color_out, 12'hAB5);
    cpu_read(5'h02, rd);
    check("copy_cycle_read", rd, 8'h00);
    vblank = 1'b0;
    step(2);
    vblank = 1'b1;
    step(6);
    check("vb2_color", color_out, 12'hCD9);
    check("vb2_layer", out_layer, 1);
    vblank = 1'b0;

    // unmapped registers
    cpu_write(5'h1F, 8'hFF);
    cpu_read(5'h1F, rd);
    check("unmapped_read", rd, 8'h00);
    cpu_write(5'h0A, 8'hAA);
    cpu_read(5'h0A, rd);
    check("layer4_read", rd, 8'h00);
    cpu_read(5'h13, rd);
    check("bg_hi_read", rd, 8'h01);
    cpu_read(5'h12, rd);
    check("bg_lo_read", rd, 8'h23);

    // asynchronous reset mid-pixel
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_color", color_out, 0);
    check("async_layer", out_layer, 0);
    check("async_dout", bus.cpu_dout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
